// File: rtl/soc_map_pkg.sv
// SoC memory map constants shared by the CPU-side SRAM responder:
// RAM depth, MMIO window base, register offsets and a byte-lane merge helper.
package soc_map_pkg;

  localparam int          MEM_LOG2_DEFAULT  = 12;
  localparam logic [31:0] MMIO_BASE_DEFAULT = 32'hBFAF_0000;

  // Word-aligned register offsets inside the MMIO window.
  localparam logic [15:0] LED_OFS     = 16'h0000;
  localparam logic [15:0] SW_OFS      = 16'h0004;
  localparam logic [15:0] TIMER_OFS   = 16'h0008;
  localparam logic [15:0] SCRATCH_OFS = 16'h000C;

  // Replace the lanes of old_word selected by we with the matching lanes of wdata.
  function automatic logic [31:0] lane_merge(input logic [31:0] old_word,
                                             input logic [31:0] wdata,
                                             input logic [3:0]  we);
    logic [31:0] res;
    res = old_word;
    for (int i = 0; i < 4; i++) begin
      if (we[i]) res[8*i +: 8] = wdata[8*i +: 8];
    end
    return res;
  endfunction

endpackage

// File: rtl/cpu_sram_responder_if.sv
// Instruction and data SRAM-style buses between the CPU (master) and the
// memory responder (slave).
// Handshake: there is no valid/ready pair. en qualifies a request and the
// responder accepts one request per port on every rising edge; read data is
// registered and appears one edge after the request, holding otherwise.
interface cpu_sram_if;
  logic        inst_sram_en;
  logic [3:0]  inst_sram_we;
  logic [31:0] inst_sram_addr;
  logic [31:0] inst_sram_wdata;
  logic [31:0] inst_sram_rdata;

  logic        data_sram_en;
  logic [3:0]  data_sram_we;
  logic [31:0] data_sram_addr;
  logic [31:0] data_sram_wdata;
  logic [31:0] data_sram_rdata;

  modport master (
    output inst_sram_en, inst_sram_we, inst_sram_addr, inst_sram_wdata,
    input  inst_sram_rdata,
    output data_sram_en, data_sram_we, data_sram_addr, data_sram_wdata,
    input  data_sram_rdata
  );

  modport slave (
    input  inst_sram_en, inst_sram_we, inst_sram_addr, inst_sram_wdata,
    output inst_sram_rdata,
    input  data_sram_en, data_sram_we, data_sram_addr, data_sram_wdata,
    output data_sram_rdata
  );
endinterface

// File: rtl/cpu_sram_responder_sram.sv
// True dual-port word RAM: port A read-only, port B read/write with byte
// enables. Both reads are registered and see the pre-write contents when the
// same word is written in the same cycle.
module sram_tdp_be #(
  parameter int AW = 12
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          a_en_i,
  input  logic [AW-1:0] a_addr_i,
  output logic [31:0]   a_rdata_o,
  input  logic          b_en_i,
  input  logic [3:0]    b_we_i,
  input  logic [AW-1:0] b_addr_i,
  input  logic [31:0]   b_wdata_i,
  output logic [31:0]   b_rdata_o
);

  logic [31:0] mem [0:(1<<AW)-1];
  logic [31:0] a_rdata_q;
  logic [31:0] b_rdata_q;

  // Byte-lane writes on port B; storage itself is never reset.
  always_ff @(posedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (b_en_i && b_we_i[i]) mem[b_addr_i][8*i +: 8] <= b_wdata_i[8*i +: 8];
    end
  end

  // Registered reads; non-blocking update gives read-before-write on collisions.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_rdata_q <= '0;
      b_rdata_q <= '0;
    end else begin
      if (a_en_i) a_rdata_q <= mem[a_addr_i];
      if (b_en_i && (b_we_i == 4'h0)) b_rdata_q <= mem[b_addr_i];
    end
  end

  assign a_rdata_o = a_rdata_q;
  assign b_rdata_o = b_rdata_q;

endmodule

// File: rtl/cpu_sram_responder.sv
// Memory-side responder for the CPU inst/data SRAM buses: unified RAM,
// MMIO window (LED, synchronized switches, free-running timer, scratch).
module cpu_sram_responder
  import soc_map_pkg::*;
#(
  parameter int          MEM_LOG2  = MEM_LOG2_DEFAULT,
  parameter logic [31:0] MMIO_BASE = MMIO_BASE_DEFAULT
) (
  input  logic        clk,
  input  logic        reset,
  cpu_sram_if.slave   bus,
  output logic [15:0] led,
  input  logic [7:0]  switch
);

  logic        inst_mmio, data_mmio;
  logic        data_rd, data_wr, mmio_wr;
  logic [15:0] ofs;
  logic        ram_a_en, ram_b_en;
  logic [3:0]  ram_b_we;
  logic [31:0] ram_a_rdata, ram_b_rdata;
  logic [31:0] mmio_rd_val;
  logic [31:0] led_merge;

  logic [15:0] led_q, led_d;
  logic [31:0] timer_q, timer_d;
  logic [31:0] scratch_q, scratch_d;
  logic [7:0]  sw_meta_q, sw_sync_q;
  logic        inst_sel_ram_q, data_sel_ram_q;
  logic [31:0] mmio_rdata_q;

  assign inst_mmio = (bus.inst_sram_addr[31:16] == MMIO_BASE[31:16]);
  assign data_mmio = (bus.data_sram_addr[31:16] == MMIO_BASE[31:16]);
  assign data_rd   = bus.data_sram_en && (bus.data_sram_we == 4'h0);
  assign data_wr   = bus.data_sram_en && (bus.data_sram_we != 4'h0);
  assign mmio_wr   = data_wr && data_mmio;
  assign ofs       = {bus.data_sram_addr[15:2], 2'b00};

  // RAM requests are masked during reset so nothing is written then.
  assign ram_a_en = bus.inst_sram_en && !inst_mmio && !reset;
  assign ram_b_en = bus.data_sram_en && !data_mmio && !reset;
  assign ram_b_we = ram_b_en ? bus.data_sram_we : 4'h0;

  sram_tdp_be #(.AW(MEM_LOG2)) u_ram (
    .clk       (clk),
    .rst       (reset),
    .a_en_i    (ram_a_en),
    .a_addr_i  (bus.inst_sram_addr[MEM_LOG2+1:2]),
    .a_rdata_o (ram_a_rdata),
    .b_en_i    (ram_b_en),
    .b_we_i    (ram_b_we),
    .b_addr_i  (bus.data_sram_addr[MEM_LOG2+1:2]),
    .b_wdata_i (bus.data_sram_wdata),
    .b_rdata_o (ram_b_rdata)
  );

  // MMIO read mux; the timer value is the one before this edge's increment.
  always_comb begin
    mmio_rd_val = 32'h0;
    case (ofs)
      LED_OFS:     mmio_rd_val = {16'h0, led_q};
      SW_OFS:      mmio_rd_val = {24'h0, sw_sync_q};
      TIMER_OFS:   mmio_rd_val = timer_q;
      SCRATCH_OFS: mmio_rd_val = scratch_q;
      default:     mmio_rd_val = 32'h0;
    endcase
  end

  // Next-state for the RW registers; a timer write suppresses the increment.
  always_comb begin
    led_merge = lane_merge({16'h0, led_q}, bus.data_sram_wdata, bus.data_sram_we);
    led_d     = led_q;
    scratch_d = scratch_q;
    timer_d   = timer_q + 32'd1;
    if (mmio_wr && (ofs == LED_OFS))     led_d     = led_merge[15:0];
    if (mmio_wr && (ofs == SCRATCH_OFS)) scratch_d = lane_merge(scratch_q, bus.data_sram_wdata, bus.data_sram_we);
    if (mmio_wr && (ofs == TIMER_OFS))   timer_d   = lane_merge(timer_q, bus.data_sram_wdata, bus.data_sram_we);
  end

  // Register file, switch synchronizer and per-port RAM/MMIO source select.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      led_q          <= '0;
      timer_q        <= '0;
      scratch_q      <= '0;
      sw_meta_q      <= '0;
      sw_sync_q      <= '0;
      inst_sel_ram_q <= 1'b0;
      data_sel_ram_q <= 1'b0;
      mmio_rdata_q   <= '0;
    end else begin
      led_q     <= led_d;
      timer_q   <= timer_d;
      scratch_q <= scratch_d;
      sw_meta_q <= switch;
      sw_sync_q <= sw_meta_q;
      if (bus.inst_sram_en) inst_sel_ram_q <= !inst_mmio;
      if (data_rd) begin
        data_sel_ram_q <= !data_mmio;
        mmio_rdata_q   <= mmio_rd_val;
      end
    end
  end

  // Outputs select between flops only; a fetch into MMIO space reads as 0.
  assign bus.inst_sram_rdata = inst_sel_ram_q ? ram_a_rdata : 32'h0;
  assign bus.data_sram_rdata = data_sel_ram_q ? ram_b_rdata : mmio_rdata_q;
  assign led                 = led_q;

  logic unused_bits;
  assign unused_bits = ^{bus.inst_sram_we, bus.inst_sram_wdata, bus.inst_sram_addr,
                         bus.data_sram_addr[1:0], led_merge[31:16]};

endmodule

// File: tb/tb_cpu_sram_responder.sv
// Bench for cpu_sram_responder: directed vector table, switch and reset
// sequences, then random traffic against a word-array reference model.
module tb_cpu_sram_responder;

  localparam logic [31:0] MB = 32'hBFAF_0000;

  logic        clk;
  logic        reset;
  logic [15:0] led;
  logic [7:0]  sw;

  cpu_sram_if bus_if();

  cpu_sram_responder dut (
    .clk    (clk),
    .reset  (reset),
    .bus    (bus_if),
    .led    (led),
    .switch (sw)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- bookkeeping ----------------
  int checks = 0;
  int errors = 0;
  logic [31:0] exp_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // ---------------- driver ----------------
  task automatic drive(input logic d_en, input logic [3:0] d_we, input logic [31:0] d_addr,
                       input logic [31:0] d_wdata, input logic i_en, input logic [31:0] i_addr);
    bus_if.data_sram_en    = d_en;
    bus_if.data_sram_we    = d_we;
    bus_if.data_sram_addr  = d_addr;
    bus_if.data_sram_wdata = d_wdata;
    bus_if.inst_sram_en    = i_en;
    bus_if.inst_sram_we    = 4'hF;
    bus_if.inst_sram_addr  = i_addr;
    bus_if.inst_sram_wdata = 32'hFFFF_FFFF;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    logic        d_en;
    logic [3:0]  d_we;
    logic [31:0] d_addr;
    logic [31:0] d_wdata;
    logic        i_en;
    logic [31:0] i_addr;
    logic        chk_d;
    logic [31:0] exp_d;
    logic        chk_i;
    logic [31:0] exp_i;
    logic        chk_led;
    logic [15:0] exp_led;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t v(logic d_en, logic [3:0] d_we, logic [31:0] d_addr, logic [31:0] d_wdata,
                             logic i_en, logic [31:0] i_addr, logic chk_d, logic [31:0] exp_d,
                             logic chk_i, logic [31:0] exp_i, logic chk_led, logic [15:0] exp_led);
    vec_t r;
    r.d_en = d_en; r.d_we = d_we; r.d_addr = d_addr; r.d_wdata = d_wdata;
    r.i_en = i_en; r.i_addr = i_addr; r.chk_d = chk_d; r.exp_d = exp_d;
    r.chk_i = chk_i; r.exp_i = exp_i; r.chk_led = chk_led; r.exp_led = exp_led;
    return r;
  endfunction

  // ---------------- reference model (random phase) ----------------
  logic [31:0] m_mem[64];
  logic [15:0] m_led;
  logic [31:0] m_timer;
  logic [31:0] m_scratch;
  logic [7:0]  sw_hist[$];
  logic [31:0] m_exp_d, m_exp_i;

  function automatic bit is_mmio(input logic [31:0] a);
    return a[31:16] == MB[31:16];
  endfunction

  function automatic logic [31:0] put_lanes(input logic [31:0] cur, input logic [31:0] wd,
                                            input logic [3:0] we);
    logic [31:0] r;
    r = cur;
    for (int i = 0; i < 4; i++) if (we[i]) r[8*i +: 8] = wd[8*i +: 8];
    return r;
  endfunction

  task automatic step(input logic d_en, input logic [3:0] d_we, input logic [31:0] d_addr,
                      input logic [31:0] d_wdata, input logic i_en, input logic [31:0] i_addr,
                      input logic [7:0] sw_val, input bit chk);
    logic [15:0] off;
    logic [31:0] t;
    bit timer_loaded;
    drive(d_en, d_we, d_addr, d_wdata, i_en, i_addr);
    sw = sw_val;
    off = d_addr[15:0] & 16'hFFFC;
    // reads see the state before this edge
    if (i_en) m_exp_i = is_mmio(i_addr) ? 32'h0 : m_mem[i_addr[7:2]];
    if (d_en && d_we == 4'h0) begin
      if (!is_mmio(d_addr)) m_exp_d = m_mem[d_addr[7:2]];
      else if (off == 16'h0) m_exp_d = {16'h0, m_led};
      else if (off == 16'h4) m_exp_d = {24'h0, sw_hist[sw_hist.size()-2]};
      else if (off == 16'h8) m_exp_d = m_timer;
      else if (off == 16'hC) m_exp_d = m_scratch;
      else m_exp_d = 32'h0;
    end
    timer_loaded = 0;
    if (d_en && d_we != 4'h0) begin
      if (!is_mmio(d_addr)) m_mem[d_addr[7:2]] = put_lanes(m_mem[d_addr[7:2]], d_wdata, d_we);
      else if (off == 16'h0) begin
        t = put_lanes({16'h0, m_led}, d_wdata, d_we);
        m_led = t[15:0];
      end
      else if (off == 16'h8) begin
        m_timer = put_lanes(m_timer, d_wdata, d_we);
        timer_loaded = 1;
      end
      else if (off == 16'hC) m_scratch = put_lanes(m_scratch, d_wdata, d_we);
    end
    if (!timer_loaded) m_timer = m_timer + 32'd1;
    sw_hist.push_back(sw_val);
    exp_q.push_back(m_exp_d);
    exp_q.push_back(m_exp_i);
    exp_q.push_back({16'h0, m_led});
    tick();
    t = exp_q.pop_front();
    if (chk) check("rand_data_rdata", bus_if.data_sram_rdata, t);
    t = exp_q.pop_front();
    if (chk) check("rand_inst_rdata", bus_if.inst_sram_rdata, t);
    t = exp_q.pop_front();
    if (chk) check("rand_led", {16'h0, led}, t);
  endtask

  function automatic logic [31:0] gen_addr(input int mmio_pct);
    logic [31:0] a;
    logic [15:0] hi;
    if (int'($urandom_range(99)) < mmio_pct) begin
      a = MB;
      a[4:2] = 3'($urandom_range(7));
      a[1:0] = 2'($urandom_range(3));
    end else begin
      hi = 16'($urandom);
      if (hi == MB[31:16]) hi = 16'h0000;
      a = {hi, 2'($urandom_range(3)), 6'b0, 6'($urandom_range(63)), 2'($urandom_range(3))};
    end
    return a;
  endfunction

  // ---------------- main test ----------------
  initial begin
    int first_hit;
    logic [7:0] sw_cur;
    logic [3:0] we;

    reset = 1'b1;
    sw = 8'h00;
    drive(0, 0, 0, 0, 0, 0);
    #3;
    check("reset_data_rdata", bus_if.data_sram_rdata, 32'h0);
    check("reset_inst_rdata", bus_if.inst_sram_rdata, 32'h0);
    check("reset_led", {16'h0, led}, 32'h0);
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;

    // Vector table: {inputs, expected after the edge}
    vecs.push_back(v(1, 4'hF, 32'h10, 32'h1122_3344, 0, 0,          0, 0,            0, 0,            0, 0));
    vecs.push_back(v(1, 4'h4, 32'h10, 32'h00AA_0000, 0, 0,          0, 0,            0, 0,            0, 0));
    vecs.push_back(v(1, 4'h0, 32'h10, 32'h0,         0, 0,          1, 32'h11AA_3344, 0, 0,           0, 0));
    vecs.push_back(v(1, 4'hF, 32'h20, 32'h0BAD_F00D, 0, 0,          1, 32'h11AA_3344, 0, 0,           0, 0));
    vecs.push_back(v(0, 4'h0, 32'h10, 32'h0,         0, 0,          1, 32'h11AA_3344, 0, 0,           0, 0));
    vecs.push_back(v(1, 4'hF, 32'h20, 32'hDEAD_BEEF, 1, 32'h20,     1, 32'h11AA_3344, 1, 32'h0BAD_F00D, 0, 0));
    vecs.push_back(v(1, 4'h0, 32'h20, 32'h0,         1, 32'h20,     1, 32'hDEAD_BEEF, 1, 32'hDEAD_BEEF, 0, 0));
    vecs.push_back(v(1, 4'h0, MB+32'h10, 32'h0,      0, 0,          1, 32'h0,         1, 32'hDEAD_BEEF, 0, 0));
    vecs.push_back(v(1, 4'hF, MB, 32'h0000_A5A5,     1, MB,         1, 32'h0,         1, 32'h0,         1, 16'hA5A5));
    vecs.push_back(v(1, 4'h0, MB, 32'h0,             0, 0,          1, 32'h0000_A5A5, 0, 0,           1, 16'hA5A5));
    vecs.push_back(v(1, 4'hF, MB+32'h8, 32'hFFFF_FFFE, 0, 0,        1, 32'h0000_A5A5, 0, 0,           0, 0));
    vecs.push_back(v(0, 4'h0, 32'h0, 32'h0,          0, 0,          1, 32'h0000_A5A5, 0, 0,           0, 0));
    vecs.push_back(v(1, 4'h0, MB+32'h8, 32'h0,       0, 0,          1, 32'hFFFF_FFFF, 0, 0,           0, 0));
    vecs.push_back(v(1, 4'h0, MB+32'h8, 32'h0,       0, 0,          1, 32'h0000_0000, 0, 0,           0, 0));
    vecs.push_back(v(1, 4'h3, MB+32'h8, 32'h0000_1234, 0, 0,        1, 32'h0000_0000, 0, 0,           0, 0));
    vecs.push_back(v(1, 4'h0, MB+32'h8, 32'h0,       0, 0,          1, 32'h0000_1234, 0, 0,           0, 0));
    vecs.push_back(v(1, 4'hA, MB+32'hC, 32'hAABB_CCDD, 0, 0,        0, 0,            0, 0,            0, 0));
    vecs.push_back(v(1, 4'h0, MB+32'hC, 32'h0,       1, MB+32'hC,   1, 32'hAA00_CC00, 1, 32'h0,       0, 0));
    vecs.push_back(v(1, 4'h2, MB, 32'h0000_3C00,     0, 0,          0, 0,            0, 0,            1, 16'h3CA5));
    vecs.push_back(v(1, 4'hF, MB+32'h10, 32'hFFFF_FFFF, 0, 0,       0, 0,            0, 0,            0, 0));
    vecs.push_back(v(1, 4'h0, MB+32'h10, 32'h0,      0, 0,          1, 32'h0,         0, 0,           0, 0));
    vecs.push_back(v(1, 4'h0, MB, 32'h0,             0, 0,          1, 32'h0000_3CA5, 0, 0,           1, 16'h3CA5));

    for (int k = 0; k < vecs.size(); k++) begin
      drive(vecs[k].d_en, vecs[k].d_we, vecs[k].d_addr, vecs[k].d_wdata, vecs[k].i_en, vecs[k].i_addr);
      tick();
      if (vecs[k].chk_d)   check($sformatf("vec%0d_data", k), bus_if.data_sram_rdata, vecs[k].exp_d);
      if (vecs[k].chk_i)   check($sformatf("vec%0d_inst", k), bus_if.inst_sram_rdata, vecs[k].exp_i);
      if (vecs[k].chk_led) check($sformatf("vec%0d_led", k), {16'h0, led}, {16'h0, vecs[k].exp_led});
    end

    // Switch: change right after an edge, read SWITCH every cycle.
    sw = 8'h5C;
    drive(1, 4'h0, MB+32'h4, 32'h0, 0, 0);
    first_hit = 0;
    for (int k = 1; k <= 8; k++) begin
      tick();
      if (first_hit == 0 && bus_if.data_sram_rdata == 32'h5C) first_hit = k;
    end
    check("switch_first_edge", 32'(first_hit), 32'd3);

    // Reset mid-run: outputs clear at once, RAM survives, accesses ignored.
    drive(1, 4'h0, MB+32'h8, 32'h0, 1, 32'h20);
    tick();
    #2 reset = 1'b1;
    #1;
    check("midreset_data_rdata", bus_if.data_sram_rdata, 32'h0);
    check("midreset_inst_rdata", bus_if.inst_sram_rdata, 32'h0);
    check("midreset_led", {16'h0, led}, 32'h0);
    drive(1, 4'hF, 32'h10, 32'hFFFF_FFFF, 1, 32'h20);
    tick();
    reset = 1'b0;
    drive(1, 4'h0, MB+32'h8, 32'h0, 1, 32'h20);
    tick();
    check("postreset_timer", bus_if.data_sram_rdata, 32'h0);
    check("postreset_inst", bus_if.inst_sram_rdata, 32'hDEAD_BEEF);
    drive(1, 4'h0, 32'h10, 32'h0, 0, 0);
    tick();
    check("postreset_ram_kept", bus_if.data_sram_rdata, 32'h11AA_3344);

    // Random phase: bring the model in sync first (unchecked cycles).
    sw_cur = sw;
    sw_hist.delete();
    sw_hist.push_back(sw_cur);
    sw_hist.push_back(sw_cur);
    m_led = 0; m_timer = 0; m_scratch = 0; m_exp_d = 0; m_exp_i = 0;
    step(1, 4'hF, MB+32'h8, $urandom, 0, 0, sw_cur, 0);
    step(1, 4'hF, MB,       $urandom, 0, 0, sw_cur, 0);
    step(1, 4'hF, MB+32'hC, $urandom, 0, 0, sw_cur, 0);
    for (int w = 0; w < 64; w++)
      step(1, 4'hF, 32'(w) << 2, $urandom, 0, 0, sw_cur, 0);
    step(1, 4'h0, 32'h0, 32'h0, 1, 32'h4, sw_cur, 0);

    for (int n = 0; n < 600; n++) begin
      logic        d_en, i_en;
      logic [31:0] d_addr, i_addr;
      d_en = ($urandom_range(99) < 75);
      we = ($urandom_range(1) == 0) ? 4'h0 : 4'($urandom_range(1, 15));
      d_addr = gen_addr(35);
      i_en = ($urandom_range(99) < 70);
      i_addr = gen_addr(15);
      if ($urandom_range(9) == 0) sw_cur = 8'($urandom);
      step(d_en, we, d_addr, $urandom, i_en, i_addr, sw_cur, 1);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
